// File: rtl/l1_dma_engine.sv
// L1 DMA engine: moves one cache line between backing memory and the L1
// instruction/data SRAMs as a single fill or writeback burst.
module l1_dma_engine #(
  parameter int DATA_WIDTH      = 32,
  parameter int ADDR_WIDTH      = 32,
  parameter int READ_BURST_LEN  = 8,
  parameter int WRITE_BURST_LEN = 8
) (
  input  logic                  cpu_clk,
  input  logic                  cpu_rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [1:0]            req_op,
  input  logic [ADDR_WIDTH-1:0] req_mem_addr,
  input  logic [ADDR_WIDTH-1:0] req_local_addr,
  output logic                  done,
  output logic                  mem_cmd_valid,
  input  logic                  mem_cmd_ready,
  output logic [ADDR_WIDTH-1:0] mem_cmd_addr,
  output logic                  mem_cmd_write,
  input  logic                  mem_rvalid,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  mem_wvalid,
  input  logic                  mem_wready,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  mem_wlast,
  output logic [ADDR_WIDTH-1:0] dma_inst_mem_waddr,
  output logic [DATA_WIDTH-1:0] dma_inst_mem_wdata,
  output logic                  inst_mem_write,
  output logic [ADDR_WIDTH-1:0] dma_data_mem_raddr,
  input  logic [DATA_WIDTH-1:0] data_mem_rdata,
  output logic                  data_mem_read_ctrl_by,
  output logic [ADDR_WIDTH-1:0] dma_data_mem_waddr,
  output logic [DATA_WIDTH-1:0] dma_data_mem_wdata,
  output logic                  data_mem_write,
  output logic                  data_mem_write_ctrl_by
);

  localparam int RD_W  = $clog2(READ_BURST_LEN);
  localparam int WR_W  = $clog2(WRITE_BURST_LEN);
  localparam int CNT_W = (RD_W > WR_W) ? RD_W : WR_W;
  localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(READ_BURST_LEN - 1);
  localparam logic [CNT_W-1:0] WR_LAST = CNT_W'(WRITE_BURST_LEN - 1);

  typedef enum logic [2:0] {IDLE, CMD, FILL, WB, DONE} state_e;

  state_e                state_q;
  logic [1:0]            op_q;
  logic [ADDR_WIDTH-1:0] maddr_q;
  logic [ADDR_WIDTH-1:0] laddr_q;
  logic [CNT_W-1:0]      cnt_q;

  logic                  in_fill;
  logic                  in_wb;
  logic                  beat;
  logic [ADDR_WIDTH-1:0] beat_addr;

  always_ff @(posedge cpu_clk or negedge cpu_rst_n) begin
    if (!cpu_rst_n) begin
      state_q <= IDLE;
      op_q    <= '0;
      maddr_q <= '0;
      laddr_q <= '0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            op_q    <= req_op;
            maddr_q <= req_mem_addr;
            laddr_q <= req_local_addr;
            cnt_q   <= '0;
            // Illegal op completes immediately without touching memory.
            state_q <= (req_op == 2'd3) ? DONE : CMD;
          end
        end
        CMD: begin
          if (mem_cmd_ready) begin
            cnt_q   <= '0;
            state_q <= (op_q == 2'd2) ? WB : FILL;
          end
        end
        FILL: begin
          if (mem_rvalid) begin
            cnt_q <= cnt_q + CNT_W'(1);
            if (cnt_q == RD_LAST) state_q <= DONE;
          end
        end
        WB: begin
          if (mem_wready) begin
            cnt_q <= cnt_q + CNT_W'(1);
            if (cnt_q == WR_LAST) state_q <= DONE;
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // Every output is decoded from the state register and gated to zero
  // outside its phase, so reset forces a quiet bus immediately.
  assign in_fill   = (state_q == FILL);
  assign in_wb     = (state_q == WB);
  assign beat      = in_fill && mem_rvalid;
  assign beat_addr = laddr_q + ADDR_WIDTH'({cnt_q, 2'b00});

  assign req_ready     = (state_q == IDLE);
  assign done          = (state_q == DONE);
  assign mem_cmd_valid = (state_q == CMD);
  assign mem_cmd_addr  = mem_cmd_valid ? maddr_q : '0;
  assign mem_cmd_write = mem_cmd_valid && (op_q == 2'd2);

  assign inst_mem_write     = beat && (op_q == 2'd0);
  assign dma_inst_mem_waddr = inst_mem_write ? beat_addr : '0;
  assign dma_inst_mem_wdata = inst_mem_write ? mem_rdata : '0;

  assign data_mem_write         = beat && (op_q == 2'd1);
  assign data_mem_write_ctrl_by = in_fill && (op_q == 2'd1);
  assign dma_data_mem_waddr     = data_mem_write ? beat_addr : '0;
  assign dma_data_mem_wdata     = data_mem_write ? mem_rdata : '0;

  assign data_mem_read_ctrl_by = in_wb;
  assign dma_data_mem_raddr    = in_wb ? beat_addr : '0;
  assign mem_wvalid            = in_wb;
  assign mem_wdata             = in_wb ? data_mem_rdata : '0;
  assign mem_wlast             = in_wb && (cnt_q == WR_LAST);

endmodule

// File: tb/tb_l1_dma_engine.sv
// Directed bench for l1_dma_engine: table-driven fill/writeback bursts plus
// hand-written command stall, illegal-op and mid-burst reset sequences.
module tb_l1_dma_engine;

  logic        cpu_clk = 1'b0;
  logic        cpu_rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_op;
  logic [31:0] req_mem_addr;
  logic [31:0] req_local_addr;
  logic        done;
  logic        mem_cmd_valid;
  logic        mem_cmd_ready;
  logic [31:0] mem_cmd_addr;
  logic        mem_cmd_write;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        mem_wvalid;
  logic        mem_wready;
  logic [31:0] mem_wdata;
  logic        mem_wlast;
  logic [31:0] dma_inst_mem_waddr;
  logic [31:0] dma_inst_mem_wdata;
  logic        inst_mem_write;
  logic [31:0] dma_data_mem_raddr;
  logic [31:0] data_mem_rdata;
  logic        data_mem_read_ctrl_by;
  logic [31:0] dma_data_mem_waddr;
  logic [31:0] dma_data_mem_wdata;
  logic        data_mem_write;
  logic        data_mem_write_ctrl_by;

  l1_dma_engine dut (
    .cpu_clk(cpu_clk), .cpu_rst_n(cpu_rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_mem_addr(req_mem_addr), .req_local_addr(req_local_addr), .done(done),
    .mem_cmd_valid(mem_cmd_valid), .mem_cmd_ready(mem_cmd_ready),
    .mem_cmd_addr(mem_cmd_addr), .mem_cmd_write(mem_cmd_write),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .mem_wvalid(mem_wvalid), .mem_wready(mem_wready), .mem_wdata(mem_wdata), .mem_wlast(mem_wlast),
    .dma_inst_mem_waddr(dma_inst_mem_waddr), .dma_inst_mem_wdata(dma_inst_mem_wdata),
    .inst_mem_write(inst_mem_write),
    .dma_data_mem_raddr(dma_data_mem_raddr), .data_mem_rdata(data_mem_rdata),
    .data_mem_read_ctrl_by(data_mem_read_ctrl_by),
    .dma_data_mem_waddr(dma_data_mem_waddr), .dma_data_mem_wdata(dma_data_mem_wdata),
    .data_mem_write(data_mem_write), .data_mem_write_ctrl_by(data_mem_write_ctrl_by)
  );

  always #5 cpu_clk = ~cpu_clk;

  // Data SRAM model: word i of any 32-byte aligned line holds 0x11*(i+1).
  logic [31:0] sram [8];
  initial for (int i = 0; i < 8; i++) sram[i] = 32'h11 * 32'(i + 1);
  assign data_mem_rdata = sram[dma_data_mem_raddr[4:2]];

  typedef struct packed {
    logic        cmd_rdy;
    logic        rv;
    logic        wrdy;
    logic [31:0] rdata;
    logic        e_cmdv;
    logic        e_cmdw;
    logic [31:0] e_cmda;
    logic        e_iwe;
    logic        e_dwe;
    logic [31:0] e_waddr;
    logic [31:0] e_wdata;
    logic        e_wctl;
    logic        e_rctl;
    logic [31:0] e_raddr;
    logic        e_wv;
    logic [31:0] e_mwdata;
    logic        e_wl;
    logic        e_done;
    logic        e_rdy;
  } vec_t;

  vec_t tab[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic quiet_nodone();
    return |{mem_cmd_valid, mem_cmd_addr, mem_cmd_write, mem_wvalid, mem_wdata, mem_wlast,
             dma_inst_mem_waddr, dma_inst_mem_wdata, inst_mem_write,
             dma_data_mem_raddr, data_mem_read_ctrl_by,
             dma_data_mem_waddr, dma_data_mem_wdata, data_mem_write, data_mem_write_ctrl_by};
  endfunction

  task automatic tick();
    @(posedge cpu_clk);
    #1;
  endtask

  task automatic accept(input logic [1:0] op, input logic [31:0] ma, input logic [31:0] la);
    req_valid      = 1'b1;
    req_op         = op;
    req_mem_addr   = ma;
    req_local_addr = la;
    #1;
    chk($sformatf("accept_ready_op%0d", op), req_ready, 1'b1);
    tick();
    req_valid    = 1'b0;
    req_op       = 2'd0;
    req_mem_addr = 32'hFFFF_FFFF;
  endtask

  task automatic run_tab(input string tag);
    for (int k = 0; k < tab.size(); k++) begin
      mem_cmd_ready = tab[k].cmd_rdy;
      mem_rvalid    = tab[k].rv;
      mem_wready    = tab[k].wrdy;
      mem_rdata     = tab[k].rdata;
      #1;
      chk($sformatf("%s[%0d].cmd_valid", tag, k), mem_cmd_valid, tab[k].e_cmdv);
      chk($sformatf("%s[%0d].cmd_write", tag, k), mem_cmd_write, tab[k].e_cmdw);
      chk($sformatf("%s[%0d].cmd_addr", tag, k), mem_cmd_addr, tab[k].e_cmda);
      chk($sformatf("%s[%0d].inst_we", tag, k), inst_mem_write, tab[k].e_iwe);
      chk($sformatf("%s[%0d].data_we", tag, k), data_mem_write, tab[k].e_dwe);
      chk($sformatf("%s[%0d].waddr", tag, k), dma_inst_mem_waddr | dma_data_mem_waddr, tab[k].e_waddr);
      chk($sformatf("%s[%0d].wdata", tag, k), dma_inst_mem_wdata | dma_data_mem_wdata, tab[k].e_wdata);
      chk($sformatf("%s[%0d].wctl", tag, k), data_mem_write_ctrl_by, tab[k].e_wctl);
      chk($sformatf("%s[%0d].rctl", tag, k), data_mem_read_ctrl_by, tab[k].e_rctl);
      chk($sformatf("%s[%0d].raddr", tag, k), dma_data_mem_raddr, tab[k].e_raddr);
      chk($sformatf("%s[%0d].wvalid", tag, k), mem_wvalid, tab[k].e_wv);
      chk($sformatf("%s[%0d].mwdata", tag, k), mem_wdata, tab[k].e_mwdata);
      chk($sformatf("%s[%0d].wlast", tag, k), mem_wlast, tab[k].e_wl);
      chk($sformatf("%s[%0d].done", tag, k), done, tab[k].e_done);
      chk($sformatf("%s[%0d].req_ready", tag, k), req_ready, tab[k].e_rdy);
      tick();
    end
    mem_cmd_ready = 1'b0;
    mem_rvalid    = 1'b0;
    mem_wready    = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    int   beats;
    int   cyc;
    cpu_rst_n = 1'b0; req_valid = 1'b0; req_op = 2'd0;
    req_mem_addr = '0; req_local_addr = '0;
    mem_cmd_ready = 1'b0; mem_rvalid = 1'b0; mem_wready = 1'b0; mem_rdata = '0;

    // Reset state
    #12;
    chk("rst_quiet", {quiet_nodone(), done}, 2'b00);
    chk("rst_ready", req_ready, 1'b1);
    tick();
    cpu_rst_n = 1'b1;
    tick();
    chk("idle_ready", req_ready, 1'b1);
    chk("idle_quiet", {quiet_nodone(), done}, 2'b00);

    // Instruction fill, no gaps: done 10 cycles after acceptance
    tab.delete();
    v = '0; v.cmd_rdy = 1; v.e_cmdv = 1; v.e_cmda = 32'h1000; tab.push_back(v);
    for (int i = 0; i < 8; i++) begin
      v = '0; v.rv = 1; v.rdata = 32'hA0 + 32'(i);
      v.e_iwe = 1; v.e_waddr = 32'h40 + 32'(4 * i); v.e_wdata = 32'hA0 + 32'(i);
      tab.push_back(v);
    end
    v = '0; v.e_done = 1; tab.push_back(v);
    v = '0; v.e_rdy = 1; tab.push_back(v);
    accept(2'd0, 32'h1000, 32'h40);
    run_tab("ifill");

    // Data fill with rvalid gaps; a beat during CMD is ignored
    tab.delete();
    v = '0; v.cmd_rdy = 1; v.rv = 1; v.rdata = 32'hFFFF_FFFF; v.e_cmdv = 1; v.e_cmda = 32'h2000;
    tab.push_back(v);
    for (int i = 0; i < 8; i++) begin
      v = '0; v.rv = 0; v.rdata = 32'hDEAD_0000 + 32'(i); v.e_wctl = 1; tab.push_back(v);
      v = '0; v.rv = 1; v.rdata = 32'hB0 + 32'(i);
      v.e_dwe = 1; v.e_wctl = 1; v.e_waddr = 32'h80 + 32'(4 * i); v.e_wdata = 32'hB0 + 32'(i);
      tab.push_back(v);
    end
    v = '0; v.e_done = 1; tab.push_back(v);
    v = '0; v.e_rdy = 1; tab.push_back(v);
    accept(2'd1, 32'h2000, 32'h80);
    run_tab("dfill");

    // Writeback with wready toggling; stray rvalid is ignored
    tab.delete();
    v = '0; v.cmd_rdy = 1; v.e_cmdv = 1; v.e_cmdw = 1; v.e_cmda = 32'h3000; tab.push_back(v);
    for (int i = 0; i < 8; i++) begin
      for (int r = 0; r < 2; r++) begin
        v = '0; v.wrdy = (r == 1); v.rv = 1; v.rdata = 32'hCAFE_0000;
        v.e_wv = 1; v.e_rctl = 1; v.e_raddr = 32'h100 + 32'(4 * i);
        v.e_mwdata = 32'h11 * 32'(i + 1); v.e_wl = (i == 7);
        tab.push_back(v);
      end
    end
    v = '0; v.e_done = 1; tab.push_back(v);
    v = '0; v.e_rdy = 1; tab.push_back(v);
    accept(2'd2, 32'h3000, 32'h100);
    run_tab("wb");

    // Command stall: command held stable, no SRAM activity
    accept(2'd2, 32'h4000, 32'h0);
    for (int i = 0; i < 5; i++) begin
      mem_cmd_ready = 1'b0; mem_rvalid = 1'b1; mem_wready = 1'b1;
      #1;
      chk($sformatf("stall%0d.cmd", i), {mem_cmd_valid, mem_cmd_write, mem_cmd_addr},
          {2'b11, 32'h4000});
      chk($sformatf("stall%0d.sram", i),
          {inst_mem_write, data_mem_write, data_mem_read_ctrl_by, data_mem_write_ctrl_by, mem_wvalid},
          5'b0);
      tick();
    end
    mem_cmd_ready = 1'b1; mem_rvalid = 1'b0;
    tick();
    mem_cmd_ready = 1'b0;
    beats = 0;
    cyc = 0;
    while (!done && cyc < 20) begin
      if (mem_wvalid && mem_wready) beats++;
      tick();
      cyc++;
    end
    mem_wready = 1'b0;
    chk("stall.done_seen", done, 1'b1);
    chk("stall.beats", beats, 8);
    tick();

    // Reset during beat 3 of a fill aborts the job
    accept(2'd0, 32'h5000, 32'h40);
    mem_cmd_ready = 1'b1;
    tick();
    mem_cmd_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      mem_rvalid = 1'b1; mem_rdata = 32'hC0 + 32'(i);
      tick();
    end
    mem_rdata = 32'hC3;
    #1;
    chk("rst_mid.pre_we", {inst_mem_write, dma_inst_mem_waddr}, {1'b1, 32'h4C});
    cpu_rst_n = 1'b0;
    #1;
    chk("rst_mid.quiet", {quiet_nodone(), done}, 2'b00);
    chk("rst_mid.ready", req_ready, 1'b1);
    for (int i = 0; i < 2; i++) begin
      tick();
      chk($sformatf("rst_hold%0d.quiet", i), {quiet_nodone(), done}, 2'b00);
    end
    cpu_rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("rst_rel%0d", i), {req_ready, done, quiet_nodone()}, 3'b100);
    end
    mem_rvalid = 1'b0;

    // Illegal op: done one cycle after acceptance, no traffic
    accept(2'd3, 32'h6000, 32'h60);
    #1;
    chk("illegal.done", done, 1'b1);
    chk("illegal.quiet", quiet_nodone(), 1'b0);
    chk("illegal.not_ready", req_ready, 1'b0);
    tick();
    chk("illegal.after", {done, req_ready, quiet_nodone()}, 3'b010);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/l1_dma_engine.md
L1_DMA_ENGINE -- requirements
Module: l1_dma_engine

Interface
REQ-001 Parameter DATA_WIDTH, default 32: memory, SRAM and burst word width.
REQ-002 Parameter ADDR_WIDTH, default 32: width of all byte addresses.
REQ-003 Parameter READ_BURST_LEN, default 8: beats per fill burst, power of two and at least 2.
REQ-004 Parameter WRITE_BURST_LEN, default 8: beats per writeback burst, power of two and at least 2.
REQ-005 The block SHALL use one clock and an asynchronous, active-low reset, with ports as follows.
REQ-006 cpu_clk  in  1  clock; all state changes on its rising edge.
REQ-007 cpu_rst_n  in  1  asynchronous active-low reset.
REQ-008 req_valid / req_ready  in / out  1 / 1  job request handshake; accepted when both are high on a clock edge.
REQ-009 req_op  in  2  0 = instruction fill, 1 = data fill, 2 = data writeback, 3 = illegal.
REQ-010 req_mem_addr / req_local_addr  in  ADDR_WIDTH each  backing-memory line base and L1 SRAM line base (byte addresses).
REQ-011 done  out  1  one-cycle pulse marking job completion.
REQ-012 mem_cmd_valid / mem_cmd_ready  out / in  1 / 1  burst command handshake.
REQ-013 mem_cmd_addr / mem_cmd_write  out  ADDR_WIDTH / 1  burst base address; direction, 1 = write.
REQ-014 mem_rvalid / mem_rdata  in  1 / DATA_WIDTH  fill beat; no backpressure, every valid beat is consumed.
REQ-015 mem_wvalid / mem_wready / mem_wdata / mem_wlast  out / in / out / out  writeback beat handshake, data and last-beat flag.
REQ-016 dma_inst_mem_waddr / dma_inst_mem_wdata / inst_mem_write  out  instruction SRAM write port.
REQ-017 dma_data_mem_raddr / data_mem_rdata / data_mem_read_ctrl_by  out / in / out  data SRAM read port and read-port ownership; data_mem_rdata is combinational from the read address.
REQ-018 dma_data_mem_waddr / dma_data_mem_wdata / data_mem_write / data_mem_write_ctrl_by  out  data SRAM write port and write-port ownership.

Function
REQ-019 The state machine SHALL have the states IDLE, CMD, FILL, WB, DONE; req_ready SHALL equal (state == IDLE).
REQ-020 On acceptance the block SHALL latch req_op, both addresses and the beat counter cleared to 0.
  - ops 0-2 go to CMD
  - op 3 goes directly to DONE with no memory or SRAM traffic
REQ-021 In CMD, mem_cmd_valid SHALL be 1, with mem_cmd_addr = latched mem address and mem_cmd_write = (op == 2).
  - all three are held stable until mem_cmd_ready
  - on mem_cmd_ready: go to FILL for ops 0/1, WB for op 2
REQ-022 In FILL, each cycle with mem_rvalid = 1 SHALL write the same cycle:
  - inst_mem_write for op 0, or data_mem_write for op 1
  - address = local base + 4*count; wdata = mem_rdata
  - then count increments
  - mem_rvalid outside FILL is ignored
REQ-023 data_mem_write_ctrl_by SHALL be 1 throughout FILL when op == 1, and 0 otherwise.
REQ-024 After beat READ_BURST_LEN-1 is written, the block SHALL go to DONE.
REQ-025 In WB, the block SHALL drive:
  - dma_data_mem_raddr = local base + 4*count
  - data_mem_read_ctrl_by = 1
  - mem_wvalid = 1, mem_wdata = data_mem_rdata
  - mem_wlast = (count == WRITE_BURST_LEN-1)
  - count advances only when mem_wready = 1
  - the last accepted beat moves to DONE
REQ-026 In DONE, done SHALL be 1 for exactly one cycle, followed by a return to IDLE; a new request is accepted no earlier than the cycle after DONE.
REQ-027 Address arithmetic SHALL wrap modulo 2^ADDR_WIDTH; the counter is clog2(burst length) bits and clears on entry to FILL and WB.
REQ-028 With zero-wait memory, a fill SHALL take 1 CMD cycle plus READ_BURST_LEN FILL cycles, with done on cycle READ_BURST_LEN+2 after acceptance.
REQ-029 SRAM write strobes, wvalid and the ownership flags SHALL never be asserted outside FILL or WB.

Reset
REQ-030 While cpu_rst_n = 0 (asynchronously), the block SHALL be in IDLE with count 0.
  - all outputs 0 except req_ready = 1
  - a reset mid-burst aborts the job with no further SRAM writes or memory beats and no done pulse

Verification
REQ-031 Inst fill: op0, mem 0x1000, local 0x40, rdata 0xA0..0xA7 with no gaps -> inst_mem_write at 0x40..0x5C with matching data; done 10 cycles after acceptance.
REQ-032 Data fill with gaps: op1, rvalid low on alternate cycles -> exactly 8 data_mem_write pulses, write_ctrl_by high throughout FILL, done after the 8th beat.
REQ-033 Writeback with backpressure: op2, SRAM words 0..7 = 0x11..0x88, wready toggling -> 8 accepted beats in order, wlast only on 0x88, mem_cmd_write = 1.
REQ-034 Command stall: cmd_ready low for 5 cycles -> cmd_valid, addr and write held stable; no SRAM activity.
REQ-035 Illegal op and reset: op3 -> done 1 cycle after acceptance with no traffic; cpu_rst_n low at beat 3 of a fill -> all outputs 0 immediately, req_ready = 1 after release.
